clk_gen_div: RTL and testbench

- Parametrised, fully synchronous multi-channel clock/enable generator. It is the all-digital successor to the fixed-ratio PLL wrapper.
- It derives CH_NUM output waveforms from sys_clk. Each channel has its own divide ratio, high time (duty) and phase offset, all loaded at runtime.
- Each channel provides a per-channel rising-edge strobe for use as a clock enable.
- A lock flag indicates that all channels are aligned and running.
- It sits beside the PLL and feeds slow logic: UART baud, LED blink, sampling strobes.

---
 rtl/clk_gen_div.sv | 150 +++++++++++++++
 tb/tb_clk_gen_div.sv | 133 +++++++++++++
 2 files changed

// File: rtl/clk_gen_div.sv
// Multi-channel programmable clock/enable generator: per-channel divide, duty and
// phase, all channels restarted together on cfg_load, with a common lock flag.

module clk_gen_div_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             preset,
  input  logic             run,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic [CNT_W-1:0] phase_in,
  input  logic             en_in,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] div_q, high_q, phase_q, cnt, cnt_nxt;
  logic             en_q, ok, err_nxt;

  assign ok      = en_q && !cfg_err;
  assign err_nxt = en_in && ((div_in < TWO) || (phase_in >= div_in));

  // Preset places the counter so the first wrap to zero lands phase cycles later.
  always_comb begin
    cnt_nxt = cnt + ONE;
    if (preset)
      cnt_nxt = (phase_q != '0) ? (div_q - phase_q) : '0;
    else if (cnt == div_q - ONE)
      cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      high_q   <= '0;
      phase_q  <= '0;
      en_q     <= 1'b0;
      cfg_err  <= 1'b0;
      cnt      <= '0;
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
    end else if (load) begin
      div_q    <= div_in;
      high_q   <= high_in;
      phase_q  <= phase_in;
      en_q     <= en_in;
      cfg_err  <= err_nxt;
      cnt      <= '0;
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
    end else if (preset || run) begin
      cnt      <= cnt_nxt;
      clk_out  <= ok && (cnt_nxt < high_q);
      clk_rise <= ok && (cnt_nxt == '0) && (high_q != '0);
    end else begin
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
    end
  end
endmodule

module clk_gen_div #(
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 16,
  parameter int LOCK_CYC = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cfg_load,
  input  logic [CH_NUM*CNT_W-1:0] cfg_div,
  input  logic [CH_NUM*CNT_W-1:0] cfg_high,
  input  logic [CH_NUM*CNT_W-1:0] cfg_phase,
  input  logic [CH_NUM-1:0]       cfg_en,
  output logic [CH_NUM-1:0]       clk_out,
  output logic [CH_NUM-1:0]       clk_rise,
  output logic [CH_NUM-1:0]       cfg_err,
  output logic                    locked
);
  localparam int              SW          = $clog2(LOCK_CYC + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(LOCK_CYC - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, SETTLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt;
  logic          ch_preset, ch_run;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ch_preset = 1'b0;
    ch_run    = 1'b0;
    if (cfg_load) begin
      state_nxt = ALIGN;
    end else begin
      case (state)
        IDLE:   state_nxt = IDLE;
        ALIGN: begin
          ch_preset = 1'b1;
          state_nxt = SETTLE;
        end
        SETTLE: begin
          ch_run = 1'b1;
          if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
        end
        RUN:    ch_run = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Channels are aligned by construction, so lock is purely a settle-time count.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      if (state == ALIGN)       settle_cnt <= '0;
      else if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
      locked <= !cfg_load && (state_nxt == RUN);
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    clk_gen_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .load     (cfg_load),
      .preset   (ch_preset),
      .run      (ch_run),
      .div_in   (cfg_div[i*CNT_W +: CNT_W]),
      .high_in  (cfg_high[i*CNT_W +: CNT_W]),
      .phase_in (cfg_phase[i*CNT_W +: CNT_W]),
      .en_in    (cfg_en[i]),
      .clk_out  (clk_out[i]),
      .clk_rise (clk_rise[i]),
      .cfg_err  (cfg_err[i])
    );
  end
endmodule

// File: tb/tb_clk_gen_div.sv
// Directed bench for clk_gen_div: table of per-channel configs with hand-derived
// 12-cycle output/strobe patterns, plus reset and abort sequences.

module tb_clk_gen_div;
  localparam int CH = 4, W = 16, LC = 8, NV = 12, NC = 12;

  logic            sys_clk = 1'b0;
  logic            sys_rst, cfg_load;
  logic [CH*W-1:0] cfg_div, cfg_high, cfg_phase;
  logic [CH-1:0]   cfg_en, clk_out, clk_rise, cfg_err;
  logic            locked;

  clk_gen_div #(.CH_NUM(CH), .CNT_W(W), .LOCK_CYC(LC)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_load(cfg_load),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
    .clk_out(clk_out), .clk_rise(clk_rise), .cfg_err(cfg_err), .locked(locked)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string name;
    int    ch, div, high, phase;
    bit    en, err;
    string out, rise;   // char k = cycle k after the ALIGN exit edge
  } vec_t;

  vec_t tbl [NV];
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] pat(input string s);
    logic [NC-1:0] p;
    for (int k = 0; k < NC; k++) p[k] = (s.getc(k) == "1");
    return p;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int d, input int h, input int p, input bit e);
    cfg_div[ch*W +: W]   = W'(d);
    cfg_high[ch*W +: W]  = W'(h);
    cfg_phase[ch*W +: W] = W'(p);
    cfg_en[ch]           = e;
  endtask

  task automatic set_defaults();
    set_ch(0, 4, 2, 0, 1'b1);
    set_ch(1, 10, 2, 0, 1'b1);
    set_ch(2, 4, 2, 1, 1'b1);
    set_ch(3, 0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [NC-1:0] ot, rt, o0;
    tbl[0]  = '{"c0_div4_h2",      0, 4, 2, 0, 1'b1, 1'b0, "110011001100", "100010001000"};
    tbl[1]  = '{"c1_div10_h2",     1, 10, 2, 0, 1'b1, 1'b0, "110000000011", "100000000010"};
    tbl[2]  = '{"c2_div4_h2_ph1",  2, 4, 2, 1, 1'b1, 1'b0, "011001100110", "010001000100"};
    tbl[3]  = '{"c3_div1_err",     3, 1, 1, 0, 1'b1, 1'b1, "000000000000", "000000000000"};
    tbl[4]  = '{"c3_ph5_div4_err", 3, 4, 2, 5, 1'b1, 1'b1, "000000000000", "000000000000"};
    tbl[5]  = '{"c0_div6_h3",      0, 6, 3, 0, 1'b1, 1'b0, "111000111000", "100000100000"};
    tbl[6]  = '{"c1_div5_h0",      1, 5, 0, 0, 1'b1, 1'b0, "000000000000", "000000000000"};
    tbl[7]  = '{"c2_div5_h5",      2, 5, 5, 0, 1'b1, 1'b0, "111111111111", "100001000010"};
    tbl[8]  = '{"c3_disabled",     3, 4, 2, 0, 1'b0, 1'b0, "000000000000", "000000000000"};
    tbl[9]  = '{"c0_div4_h3_ph2",  0, 4, 3, 2, 1'b1, 1'b0, "101110111011", "001000100010"};
    tbl[10] = '{"c1_div3_h9",      1, 3, 9, 0, 1'b1, 1'b0, "111111111111", "100100100100"};
    tbl[11] = '{"c3_ph4_div4_err", 3, 4, 2, 4, 1'b1, 1'b1, "000000000000", "000000000000"};

    // Reset held with a concurrent cfg_load: reset must win.
    sys_rst = 1'b1; cfg_load = 1'b1; set_defaults();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_out", clk_out, 0); chk("rst_rise", clk_rise, 0);
      chk("rst_err", cfg_err, 0); chk("rst_lock", locked, 0);
    end
    sys_rst = 1'b0; cfg_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_out", clk_out, 0); chk("idle_lock", locked, 0);
    end

    // Vectors run back to back, so each load after the first aborts a locked RUN.
    for (int v = 0; v < NV; v++) begin
      set_defaults();
      set_ch(tbl[v].ch, tbl[v].div, tbl[v].high, tbl[v].phase, tbl[v].en);
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      cfg_div = '1; cfg_high = '0; cfg_phase = '1; cfg_en = '1;  // ignored without load
      chk({tbl[v].name, "_align_out"}, clk_out, 0);
      chk({tbl[v].name, "_align_rise"}, clk_rise, 0);
      chk({tbl[v].name, "_align_lock"}, locked, 0);
      chk({tbl[v].name, "_err"}, cfg_err[tbl[v].ch], tbl[v].err);
      for (int k = 0; k < NC; k++) begin
        tick();
        ot[k] = clk_out[tbl[v].ch];
        rt[k] = clk_rise[tbl[v].ch];
        o0[k] = clk_out[0];
        if (k == LC - 1) chk({tbl[v].name, "_lock_early"}, locked, 0);
        if (k == LC)     chk({tbl[v].name, "_lock"}, locked, 1);
      end
      chk({tbl[v].name, "_out"}, ot, pat(tbl[v].out));
      chk({tbl[v].name, "_rise"}, rt, pat(tbl[v].rise));
      if (tbl[v].ch != 0) chk({tbl[v].name, "_ch0_out"}, o0, pat("110011001100"));
      chk({tbl[v].name, "_lock_hold"}, locked, 1);
    end

    // Reset mid-RUN clears everything including a latched cfg_err.
    chk("pre_rst_err", cfg_err[3], 1);
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_out", clk_out, 0); chk("mid_rst_err", cfg_err, 0);
    chk("mid_rst_lock", locked, 0);
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_out", clk_out, 0); chk("post_rst_rise", clk_rise, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
